// File: rtl/haar_scan_window_generator_if.sv
// Pixel-stream bundle for the scan-window generator.
// Master drives the camera side, slave is the generator.
interface haar_scan_window_generator_if #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_SCALES = 2,
  parameter int FCNT_WIDTH = 16
);
  logic                           i_valid;
  logic                           i_sof;
  logic [DATA_WIDTH-1:0]          i_pixel;
  logic                           i_hold;
  logic                           o_ready;
  logic                           o_valid;
  logic [DATA_WIDTH-1:0]          o_pixel;
  logic [DATA_WIDTH-1:0]          o_ori_x;
  logic [DATA_WIDTH-1:0]          o_ori_y;
  logic                           o_frame_start;
  logic                           o_frame_end;
  logic [NUM_SCALES-1:0]          o_scale_valid;
  logic [NUM_SCALES*DATA_WIDTH-1:0] o_scale_x;
  logic [NUM_SCALES*DATA_WIDTH-1:0] o_scale_y;
  logic [NUM_SCALES-1:0]          o_window_valid;
  logic                           o_resync;
  logic                           o_drop;
  logic [FCNT_WIDTH-1:0]          o_frame_count;

  modport master (
    output i_valid, i_sof, i_pixel, i_hold,
    input  o_ready, o_valid, o_pixel, o_ori_x, o_ori_y,
    input  o_frame_start, o_frame_end, o_scale_valid,
    input  o_scale_x, o_scale_y, o_window_valid,
    input  o_resync, o_drop, o_frame_count
  );

  modport slave (
    input  i_valid, i_sof, i_pixel, i_hold,
    output o_ready, o_valid, o_pixel, o_ori_x, o_ori_y,
    output o_frame_start, o_frame_end, o_scale_valid,
    output o_scale_x, o_scale_y, o_window_valid,
    output o_resync, o_drop, o_frame_count
  );
endinterface

// File: rtl/haar_scan_window_generator.sv
// Pixel (x,y) tracker with SOF resync, power-of-2 scale
// decimation and per-scale detection-window strobes.
module haar_scan_window_generator #(
  parameter int DATA_WIDTH   = 12,
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 240,
  parameter int WINDOW_SIZE  = 24,
  parameter int NUM_SCALES   = 2,
  parameter int STRIDE_LOG2  = 0,
  parameter int FCNT_WIDTH   = 16
) (
  input  logic clk_os,
  input  logic reset_fpga,
  haar_scan_window_generator_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int SW = NUM_SCALES * DATA_WIDTH;
  localparam logic [DW-1:0] XMAX  = DW'(FRAME_WIDTH - 1);
  localparam logic [DW-1:0] YMAX  = DW'(FRAME_HEIGHT - 1);
  localparam logic [DW-1:0] WLIM  = DW'(WINDOW_SIZE - 1);
  localparam logic [DW-1:0] SMASK = DW'((2 ** STRIDE_LOG2) - 1);

  if (FRAME_WIDTH >= 2 ** DATA_WIDTH ||
      FRAME_HEIGHT >= 2 ** DATA_WIDTH ||
      NUM_SCALES < 1) begin : g_bad_params
    $error("haar_scan_window_generator: bad parameters");
  end

  logic                  accept;
  logic [DW-1:0]         px, py;
  logic                  last_x, last_y;
  logic [NUM_SCALES-1:0] kept, win;
  logic [SW-1:0]         sxp, syp;

  logic [DW-1:0]         x_q, x_d, y_q, y_d;
  logic                  valid_q, valid_d;
  logic [DW-1:0]         pixel_q, pixel_d;
  logic [DW-1:0]         ori_x_q, ori_x_d, ori_y_q, ori_y_d;
  logic                  fs_q, fs_d, fe_q, fe_d;
  logic [NUM_SCALES-1:0] sv_q, sv_d, win_q, win_d;
  logic [SW-1:0]         sx_q, sx_d, sy_q, sy_d;
  logic                  resync_q, resync_d;
  logic                  drop_q, drop_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;

  // Coordinate the accepted pixel is reported at (SOF forces origin)
  assign accept = bus.i_valid & ~bus.i_hold;
  assign px     = bus.i_sof ? '0 : x_q;
  assign py     = bus.i_sof ? '0 : y_q;
  assign last_x = (px == XMAX);
  assign last_y = (py == YMAX);

  for (genvar s = 0; s < NUM_SCALES; s++) begin : g_scale
    localparam logic [DW-1:0] KMASK = DW'((2 ** s) - 1);
    logic [DW-1:0] sx, sy;
    assign sx = px >> s;
    assign sy = py >> s;
    assign kept[s] = ((px & KMASK) == '0) && ((py & KMASK) == '0);
    assign win[s] = kept[s] && (sx >= WLIM) && (sy >= WLIM) &&
                    (((sx - WLIM) & SMASK) == '0) &&
                    (((sy - WLIM) & SMASK) == '0);
    assign sxp[s*DW +: DW] = sx;
    assign syp[s*DW +: DW] = sy;
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    valid_d  = 1'b0;
    pixel_d  = pixel_q;
    ori_x_d  = ori_x_q;
    ori_y_d  = ori_y_q;
    fs_d     = 1'b0;
    fe_d     = 1'b0;
    sv_d     = '0;
    win_d    = '0;
    sx_d     = sx_q;
    sy_d     = sy_q;
    resync_d = 1'b0;
    drop_d   = drop_q | (bus.i_valid & bus.i_hold);
    fcnt_d   = fcnt_q;
    if (accept) begin
      x_d      = last_x ? '0 : px + 1'b1;
      y_d      = last_x ? (last_y ? '0 : py + 1'b1) : py;
      valid_d  = 1'b1;
      pixel_d  = bus.i_pixel;
      ori_x_d  = px;
      ori_y_d  = py;
      fs_d     = (px == '0) && (py == '0);
      fe_d     = last_x && last_y;
      sv_d     = kept;
      win_d    = win;
      sx_d     = sxp;
      sy_d     = syp;
      resync_d = bus.i_sof && ((x_q != '0) || (y_q != '0));
      if (last_x && last_y) fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_os or posedge reset_fpga) begin
    if (reset_fpga) begin
      x_q      <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      pixel_q  <= '0;
      ori_x_q  <= '0;
      ori_y_q  <= '0;
      fs_q     <= 1'b0;
      fe_q     <= 1'b0;
      sv_q     <= '0;
      win_q    <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      resync_q <= 1'b0;
      drop_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      pixel_q  <= pixel_d;
      ori_x_q  <= ori_x_d;
      ori_y_q  <= ori_y_d;
      fs_q     <= fs_d;
      fe_q     <= fe_d;
      sv_q     <= sv_d;
      win_q    <= win_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      resync_q <= resync_d;
      drop_q   <= drop_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign bus.o_ready        = ~bus.i_hold;
  assign bus.o_valid        = valid_q;
  assign bus.o_pixel        = pixel_q;
  assign bus.o_ori_x        = ori_x_q;
  assign bus.o_ori_y        = ori_y_q;
  assign bus.o_frame_start  = fs_q;
  assign bus.o_frame_end    = fe_q;
  assign bus.o_scale_valid  = sv_q;
  assign bus.o_scale_x      = sx_q;
  assign bus.o_scale_y      = sy_q;
  assign bus.o_window_valid = win_q;
  assign bus.o_resync       = resync_q;
  assign bus.o_drop         = drop_q;
  assign bus.o_frame_count  = fcnt_q;
endmodule

// File: tb/tb_haar_scan_window_generator.sv
// Scoreboard bench: 10x10 frame, window 4, two scales,
// stride 1 and stride 2 instances fed the same stream.
module tb_haar_scan_window_generator;
  localparam int DW = 12;
  localparam int FW = 10;
  localparam int FH = 10;
  localparam int WS = 4;
  localparam int NS = 2;
  localparam int FC = 16;

  logic clk = 0;
  logic rst = 0;
  logic valid = 0;
  logic sof = 0;
  logic hold = 0;
  logic [DW-1:0] pixel = '0;

  always #5 clk = ~clk;

  haar_scan_window_generator_if #(.DATA_WIDTH(DW), .NUM_SCALES(NS),
    .FCNT_WIDTH(FC)) ia ();
  haar_scan_window_generator_if #(.DATA_WIDTH(DW), .NUM_SCALES(NS),
    .FCNT_WIDTH(FC)) ib ();

  assign ia.i_valid = valid;
  assign ia.i_sof   = sof;
  assign ia.i_hold  = hold;
  assign ia.i_pixel = pixel;
  assign ib.i_valid = valid;
  assign ib.i_sof   = sof;
  assign ib.i_hold  = hold;
  assign ib.i_pixel = pixel;

  haar_scan_window_generator #(
    .DATA_WIDTH(DW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
    .WINDOW_SIZE(WS), .NUM_SCALES(NS), .STRIDE_LOG2(0),
    .FCNT_WIDTH(FC)
  ) dut_a (.clk_os(clk), .reset_fpga(rst), .bus(ia));

  haar_scan_window_generator #(
    .DATA_WIDTH(DW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
    .WINDOW_SIZE(WS), .NUM_SCALES(NS), .STRIDE_LOG2(1),
    .FCNT_WIDTH(FC)
  ) dut_b (.clk_os(clk), .reset_fpga(rst), .bus(ib));

  typedef struct {
    logic [DW-1:0] pix, x, y;
    logic fs, fe, resync, drop;
    logic [NS-1:0] sv, win, winb;
    logic [NS*DW-1:0] sx, sy;
    logic [FC-1:0] fc;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int idx = 0;
  int fcount = 0;
  bit drop_m = 0;
  int w0 = 0, w1 = 0, wb0 = 0, rs = 0;

  function automatic void chk(string n, longint unsigned act,
                              longint unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  function automatic bit win_at(int x, int y, int s, int st);
    int d = 1 << s;
    int p = 1 << st;
    int sx = x / d;
    int sy = y / d;
    if (x % d != 0 || y % d != 0) return 0;
    return sx >= WS - 1 && sy >= WS - 1 &&
           (sx - (WS - 1)) % p == 0 && (sy - (WS - 1)) % p == 0;
  endfunction

  task automatic cyc(input bit v, input bit s, input bit h);
    exp_t e;
    int x, y;
    @(posedge clk);
    #1;
    valid = v;
    sof = s;
    hold = h;
    pixel = DW'($urandom);
    if (v && h) drop_m = 1;
    if (v && !h) begin
      e.resync = s && idx != 0;
      if (s) idx = 0;
      x = idx % FW;
      y = idx / FW;
      e.pix = pixel;
      e.x = DW'(x);
      e.y = DW'(y);
      e.fs = idx == 0;
      e.fe = idx == FW * FH - 1;
      if (e.fe) fcount++;
      e.fc = FC'(fcount);
      e.drop = drop_m;
      for (int k = 0; k < NS; k++) begin
        e.sv[k] = (x % (1 << k) == 0) && (y % (1 << k) == 0);
        e.win[k] = win_at(x, y, k, 0);
        e.winb[k] = win_at(x, y, k, 1);
        e.sx[k*DW +: DW] = DW'(x >> k);
        e.sy[k*DW +: DW] = DW'(y >> k);
      end
      idx = (idx + 1) % (FW * FH);
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("o_ready", ia.o_ready, !hold);
      if (ia.o_valid) begin
        chk("valid_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("pixel", ia.o_pixel, e.pix);
          chk("ori_x", ia.o_ori_x, e.x);
          chk("ori_y", ia.o_ori_y, e.y);
          chk("frame_start", ia.o_frame_start, e.fs);
          chk("frame_end", ia.o_frame_end, e.fe);
          chk("scale_valid", ia.o_scale_valid, e.sv);
          chk("scale_x", ia.o_scale_x, e.sx);
          chk("scale_y", ia.o_scale_y, e.sy);
          chk("window_valid", ia.o_window_valid, e.win);
          chk("window_valid_stride2", ib.o_window_valid, e.winb);
          chk("resync", ia.o_resync, e.resync);
          chk("drop", ia.o_drop, e.drop);
          chk("frame_count", ia.o_frame_count, e.fc);
        end
        if (ia.o_window_valid[0]) w0++;
        if (ia.o_window_valid[1]) w1++;
        if (ib.o_window_valid[0]) wb0++;
        if (ia.o_resync) rs++;
      end else begin
        chk("idle_window", ia.o_window_valid, 0);
        chk("idle_resync", ia.o_resync, 0);
        chk("idle_frame_end", ia.o_frame_end, 0);
      end
    end
  end

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, ia.o_valid, 0);
    chk({tag, "_pixel"}, ia.o_pixel, 0);
    chk({tag, "_ori_x"}, ia.o_ori_x, 0);
    chk({tag, "_ori_y"}, ia.o_ori_y, 0);
    chk({tag, "_scale_x"}, ia.o_scale_x, 0);
    chk({tag, "_drop"}, ia.o_drop, 0);
    chk({tag, "_frame_count"}, ia.o_frame_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, sb, r0;
    #1 rst = 1;
    hold = 1;
    #2;
    chk_zero("reset");
    chk("reset_ready", ia.o_ready, 0);
    hold = 0;
    #1;
    chk("reset_ready_follow", ia.o_ready, 1);
    @(posedge clk);
    #1 rst = 0;

    s0 = w0; s1 = w1; sb = wb0; r0 = rs;
    cyc(1, 1, 0);
    for (int i = 1; i < FW * FH; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    @(negedge clk);
    #1;
    chk("frame1_win0", w0 - s0, 49);
    chk("frame1_win1", w1 - s1, 4);
    chk("frame1_win0_stride2", wb0 - sb, 16);
    chk("frame1_resyncs", rs - r0, 0);
    chk("frame1_count", ia.o_frame_count, 1);

    while (idx != 13) cyc(1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1);
    cyc(0, 0, 0);
    @(negedge clk);
    #1;
    chk("hold_drop", ia.o_drop, 1);
    chk("hold_no_valid", ia.o_valid, 0);

    while (idx != 24) cyc(1, 0, 0);
    r0 = rs;
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    @(negedge clk);
    #1;
    chk("sof_resync_pulse", rs - r0, 1);
    chk("sof_count_kept", ia.o_frame_count, 1);

    while (idx != 55) cyc(1, 0, 0);
    cyc(0, 0, 0);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk_zero("midreset");
    idx = 0;
    fcount = 0;
    drop_m = 0;
    @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < 700; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0,
          $urandom_range(0, 7) == 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    @(negedge clk);
    #1;
    chk("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
